// File: rtl/shift_pkg.sv
// Shared constants and state type for the iterative right-shift unit.
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // Stage index of the first (largest, 16-bit) shift step.
  localparam logic [2:0] STAGE_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shiftright_stage.sv
// One power-of-two right-shift step (2^stage_i bit positions).
// With SRL_ROTATE_EN defined, rot_i selects rotate-right and fill_i is ignored.
module shiftright_stage
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       stage_i,
  input  logic             fill_i,
  input  logic             en_i,
`ifdef SRL_ROTATE_EN
  input  logic             rot_i,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [SHAMT_W-1:0] sh_amt;
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   fill_mask;
  logic [WIDTH-1:0]   wrapped;

  assign sh_amt    = SHAMT_W'(1) << stage_i;
  assign shifted   = data_i >> sh_amt;
  // Ones in the vacated MSB positions; used for sign fill.
  assign fill_mask = ~({WIDTH{1'b1}} >> sh_amt);
  // Bits shifted out of the LSBs, moved up to the vacated MSBs.
  assign wrapped   = data_i << (6'd32 - {1'b0, sh_amt});

  // Select fill or rotate for the vacated bits; pass through when disabled.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
`ifdef SRL_ROTATE_EN
      if (rot_i) begin
        data_o = shifted | wrapped;
      end else begin
        data_o = shifted | (fill_i ? fill_mask : '0);
      end
`else
      data_o = shifted | (fill_i ? fill_mask : '0);
`endif
    end
  end

`ifndef SRL_ROTATE_EN
  logic unused_wrapped;
  assign unused_wrapped = ^wrapped;
`endif

endmodule

// File: rtl/srl_sra_iter.sv
// Iterative logical/arithmetic right shifter: one stage (16,8,4,2,1) per clock,
// fixed 6-cycle latency from start to result_rdy.
// Optional macro SRL_ROTATE_EN adds the rot input (rotate-right mode).
module srl_sra_iter
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
`ifdef SRL_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   result,
  output logic               result_rdy,
  output logic               busy
);

  import shift_pkg::*;

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [SHAMT_W-1:0] amt_q;
  logic [SHAMT_W-1:0] amt_at_cnt;
  logic               fill_q;
  logic [2:0]         cnt_q;
  logic               rdy_q;
  logic               busy_q;
`ifdef SRL_ROTATE_EN
  logic               rot_q;
`endif

  // Bit of the shift amount that belongs to the current stage.
  assign amt_at_cnt = amt_q >> cnt_q;

  shiftright_stage u_stage (
    .data_i  (work_q),
    .stage_i (cnt_q),
    .fill_i  (fill_q),
    .en_i    (amt_at_cnt[0]),
`ifdef SRL_ROTATE_EN
    .rot_i   (rot_q),
`endif
    .data_o  (work_d)
  );

  // Control FSM and datapath registers; all step on every clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      cnt_q   <= STAGE_LAST;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SRL_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          rdy_q <= 1'b0;
          if (start) begin
            work_q  <= data_operand;
            amt_q   <= shamt;
            fill_q  <= arith & data_operand[WIDTH-1];
            cnt_q   <= STAGE_LAST;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef SRL_ROTATE_EN
            rot_q   <= rot;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          if (cnt_q == 3'd0) begin
            state_q <= DONE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result     = work_q;
  assign result_rdy = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_srl_sra_iter.sv
// Self-checking bench for srl_sra_iter: directed boundary cases plus random
// operations compared against an arithmetic reference model.
module tb_srl_sra_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_operand = '0;
  logic [4:0]  shamt = '0;
  logic        arith = 1'b0;
  logic        rot = 1'b0;
  logic [31:0] result;
  logic        result_rdy;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  srl_sra_iter dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .data_operand (data_operand),
    .shamt        (shamt),
    .arith        (arith),
`ifdef SRL_ROTATE_EN
    .rot          (rot),
`endif
    .result       (result),
    .result_rdy   (result_rdy),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Reference: plain shift/rotate arithmetic on the whole operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] sh,
                                            input logic ar, input logic rt);
    logic [63:0] dbl;
    if (rt) begin
      dbl = {op, op} >> sh;
      return dbl[31:0];
    end
    if (ar && op[31]) return ~((~op) >> sh);
    return op >> sh;
  endfunction

  // Launch one op from a negedge; returns at the negedge of the result_rdy cycle
  // (or after a bounded wait). lat counts negedges after acceptance, -1 on timeout.
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input logic ar,
                        input logic rt, output int lat, output logic [31:0] res,
                        output int busy_cnt);
    data_operand = op; shamt = sh; arith = ar; rot = rt; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    data_operand = $urandom; shamt = 5'($urandom); arith = 1'($urandom); rot = 1'($urandom);
    lat = -1; res = '0; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (result_rdy) begin
        lat = k; res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({result, result_rdy, busy} !== 34'd0)
      $display("FAIL reset_state: result=%h rdy=%b busy=%b, required 0/0/0", result, result_rdy, busy);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_logical();
    int lat, bc; logic [31:0] res;
    run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0, lat, res, bc);
    n_checks++;
    if (lat !== 5) $display("FAIL srl31_latency: got %0d, required 5", lat); else n_pass++;
    n_checks++;
    if (res !== 32'h0000_0001) $display("FAIL srl31_result: got %h, required 00000001", res); else n_pass++;
    n_checks++;
    if (bc !== 5) $display("FAIL srl31_busy_cycles: got %0d, required 5", bc); else n_pass++;
    // Pulse is one cycle wide and result is held in IDLE.
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (result_rdy !== 1'b0 || result !== 32'h0000_0001)
        $display("FAIL hold_after_done: rdy=%b result=%h, required 0/00000001", result_rdy, result);
      else n_pass++;
    end
  endtask

  task automatic test_arith();
    int lat, bc; logic [31:0] res;
    run_op(32'hF000_0000, 5'd4, 1'b1, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'hFF00_0000 || lat !== 5)
      $display("FAIL sra4: got %h lat %0d, required ff000000 lat 5", res, lat);
    else n_pass++;
    @(negedge clock);
    run_op(32'hF000_0000, 5'd4, 1'b0, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'h0F00_0000 || lat !== 5)
      $display("FAIL srl4: got %h lat %0d, required 0f000000 lat 5", res, lat);
    else n_pass++;
    @(negedge clock);
    run_op(32'h8000_1234, 5'd31, 1'b1, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL sra31_neg: got %h, required ffffffff", res); else n_pass++;
    @(negedge clock);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'h0000_0000) $display("FAIL sra31_pos: got %h, required 00000000", res); else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_zero_shift();
    int lat, bc; logic [31:0] res;
    run_op(32'h1234_5678, 5'd0, 1'b1, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'h1234_5678 || lat !== 5)
      $display("FAIL zero_shift: got %h lat %0d, required 12345678 lat 5", res, lat);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int rdy_seen = 0;
    int lat = -1;
    data_operand = 32'hFFFF_0000; shamt = 5'd8; arith = 1'b0; rot = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (result_rdy) rdy_seen++;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b_busy[%0d]: got %b, required 1", k, busy); else n_pass++;
      start = 1'b1; data_operand = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    end
    @(negedge clock);
    n_checks++;
    if (result_rdy !== 1'b1 || result !== 32'h00FF_FF00 || rdy_seen != 0)
      $display("FAIL ignored_start: rdy=%b result=%h early=%0d, required 1/00ffff00/0",
               result_rdy, result, rdy_seen);
    else n_pass++;
    data_operand = 32'h0000_0100; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (result_rdy) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 5 || result !== 32'h0000_0001)
      $display("FAIL start_in_done: lat %0d result %h, required lat 5 result 00000001", lat, result);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [31:0] res;
    int rdy_seen = 0;
    data_operand = 32'hDEAD_BEEF; shamt = 5'd7; arith = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({result, result_rdy, busy} !== 34'd0)
      $display("FAIL reset_mid: result=%h rdy=%b busy=%b, required 0/0/0", result, result_rdy, busy);
    else n_pass++;
    reset = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (result_rdy || busy) rdy_seen++;
    end
    n_checks++;
    if (rdy_seen != 0) $display("FAIL reset_discard: activity %0d cycles, required 0", rdy_seen); else n_pass++;
    run_op(32'h0000_0010, 5'd4, 1'b0, 1'b0, lat, res, bc);
    n_checks++;
    if (res !== 32'h0000_0001 || lat !== 5)
      $display("FAIL after_reset_op: got %h lat %0d, required 00000001 lat 5", res, lat);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_random();
    int lat, bc; logic [31:0] res, op, exp_v;
    logic [4:0] sh; logic ar, rt;
    for (int i = 0; i < 40; i++) begin
      op = $urandom; sh = 5'($urandom); ar = 1'($urandom);
`ifdef SRL_ROTATE_EN
      rt = 1'($urandom);
`else
      rt = 1'b0;
`endif
      exp_v = ref_shift(op, sh, ar && !rt, rt);
      run_op(op, sh, ar, rt, lat, res, bc);
      n_checks++;
      if (res !== exp_v || lat !== 5 || bc !== 5)
        $display("FAIL random[%0d] op=%h sh=%0d ar=%b rot=%b: got %h lat %0d busy %0d, required %h lat 5 busy 5",
                 i, op, sh, ar, rt, res, lat, bc, exp_v);
      else n_pass++;
      if ($urandom_range(1, 0) == 1) @(negedge clock);
    end
  endtask

`ifdef SRL_ROTATE_EN
  task automatic test_rotate();
    int lat, bc; logic [31:0] res;
    run_op(32'h0000_0001, 5'd1, 1'b0, 1'b1, lat, res, bc);
    n_checks++;
    if (res !== 32'h8000_0000 || lat !== 5)
      $display("FAIL rotate1: got %h lat %0d, required 80000000 lat 5", res, lat);
    else n_pass++;
    @(negedge clock);
    run_op(32'h8000_00F1, 5'd4, 1'b1, 1'b1, lat, res, bc);
    n_checks++;
    if (res !== 32'h1800_000F) $display("FAIL rotate4_arith_ignored: got %h, required 1800000f", res); else n_pass++;
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_shift();
    test_back_to_back();
    test_reset_mid();
`ifdef SRL_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/srl_sra_iter.md
Name: srl_sra_iter

Overview:
- Multi-cycle right-shift unit: logical (srl) or arithmetic (sra) shift of a 32-bit operand by a 5-bit amount.
- Resolves one power-of-two stage per clock (16, 8, 4, 2, 1), reusing a single stage register instead of a full combinational barrel.
- Sits beside the ALU/multdiv path in the execute stage, with a start/ready handshake like the other multi-cycle units.

Parameters:
- WIDTH, 32, operand/result width; must be 32 (stage amounts fixed at 16/8/4/2/1).
- SHAMT_W, 5, shift-amount width; fixed at log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on rising edge when unit is IDLE or DONE.
- data_operand  input  32  value to shift; captured when start is accepted.
- shamt  input  5  shift amount; captured when start is accepted.
- arith  input  1  0 = logical (zero fill), 1 = arithmetic (fill with captured operand bit 31).
- result  output  32  shifted value; valid when result_rdy=1, held until next accepted start.
- result_rdy  output  1  one-cycle pulse, result valid.
- busy  output  1  high while in SHIFT.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: work[31:0], amt[4:0], fill bit, stage counter cnt[2:0].
- Reset (synchronous, any state, including mid-SHIFT): state=IDLE, work=0, amt=0, cnt=4, result=0, result_rdy=0, busy=0. Any in-flight operation is discarded with no result_rdy.
- IDLE/DONE with start=1 at edge: work<=data_operand, amt<=shamt, fill<=arith & data_operand[31], cnt<=4, state<=SHIFT.
- SHIFT, each edge: if amt[cnt], work<=work shifted right by 2^cnt with fill bit in the vacated MSBs; otherwise work unchanged. If cnt==0, state<=DONE; else cnt<=cnt-1.
- DONE: result_rdy=1 for exactly this cycle. Next edge goes to IDLE, or to SHIFT if start=1.
- Latency: fixed. Start accepted at edge N gives result_rdy high in the cycle after edge N+5, for every shamt including 0. Throughput is one operation per 6 cycles (back-to-back start accepted in the DONE cycle).
- start while in SHIFT: ignored, with no queuing. Inputs may change freely after acceptance.
- result is driven from work. It is stable from DONE until the next accepted start; it is not cleared on return to IDLE.
- busy = (state==SHIFT).
- Boundaries:
  - shamt=0: result = operand.
  - shamt=31, logical: result = bit 31 of operand in bit 0, zeros above.
  - shamt=31, arithmetic: result is all copies of bit 31.
  - No wrap-around of shift amount.

Optional Feature:
- Macro SRL_ROTATE_EN.
- Defined: extra input port rot (1 bit), captured with start. When rot=1, each stage is rotate-right (vacated MSBs take the bits shifted out of the LSBs) and arith is ignored. Latency unchanged.
- Undefined: rot port absent; only logical/arithmetic shift supported.

Decomposition:
- Shared package shift_pkg: SHAMT_W and WIDTH constants, state typedef {IDLE, SHIFT, DONE}, STAGE_LAST=3'd4.
- Natural sub-module: shiftright_stage. It is combinational, takes a 32-bit in, a 3-bit stage index, a fill bit, an enable and (under SRL_ROTATE_EN) rot, and produces a 32-bit out. It is instanced once and feeds work each cycle.

Test Plan:
- Logical shift: start with data_operand=0x80000000, shamt=31, arith=0 -> result_rdy high 6 cycles after start's cycle, result=0x00000001, busy high for exactly 5 cycles.
- Arithmetic shift: data_operand=0xF0000000, shamt=4, arith=1 -> result=0xFF000000. Same operand with arith=0 -> result=0x0F000000.
- Zero shift: shamt=0, data_operand=0x12345678 -> result=0x12345678 with the full 6-cycle latency.
- Back-to-back and ignored start:
  - start (0xFFFF0000, shamt=8, arith=0), then start pulses during SHIFT with other data -> one result_rdy with 0x00FFFF00.
  - start asserted in the DONE cycle (0x00000100, shamt=8) -> next result 0x00000001 exactly 6 cycles later.
- Reset mid-operation: reset at the 3rd SHIFT cycle -> next cycle state IDLE, result=0, no result_rdy. A fresh op (0x00000010, shamt=4) then returns 0x00000001.
- With SRL_ROTATE_EN: data_operand=0x00000001, shamt=1, rot=1 -> result=0x80000000.
